sram_1r1w_param: RTL and testbench

// - Parametrised 1-read/1-write synchronous memory; successor to the fixed 64x52 1R1W macro wrappers.
// - Adds the following over those wrappers:
//   - Generic DEPTH/WIDTH.
//   - Per-lane write mask.
//   - Registered read with a valid flag.
//   - Write-to-read bypass on same-address collision.
//   - Self-clearing init FSM after reset.
// - Used for predictor tables, tag arrays and small buffers.

---
 rtl/sram_1r1w_param.sv | 122 ++++++++++++
 tb/tb_sram_1r1w_param.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sram_1r1w_param.sv
// Parametrised 1R1W synchronous memory: lane write mask, write-first bypass, registered read
// and self-clearing init after reset. Define SRAM_1R1W_PARITY_EN for per-lane even parity.
module sram_1r1w_param #(
  parameter  int DEPTH  = 64,
  parameter  int WIDTH  = 52,
  parameter  int LANE_W = 13,
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LANES  = WIDTH / LANE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              init_done,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [WIDTH-1:0]  write_data,
  input  logic [LANES-1:0]  write_mask,
  input  logic              read_en,
  input  logic [ADDR_W-1:0] read_addr,
  output logic [WIDTH-1:0]  read_data,
  output logic              read_valid,
  output logic              parity_err
);

  if (WIDTH % LANE_W != 0) begin : g_bad_lane
    $error("sram_1r1w_param: WIDTH must be a multiple of LANE_W");
  end

  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {S_INIT, S_READY} state_t;

  state_t            state;
  logic [ADDR_W-1:0] init_cnt;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic              wr_in, rd_in, wr_ok;
  logic [WIDTH-1:0]  rd_word;
`ifdef SRAM_1R1W_PARITY_EN
  logic [LANES-1:0]  par_mem [DEPTH];
  logic              rd_err;
`endif

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    wr_in   = ({1'b0, write_addr} < DEPTH_EXT);
    rd_in   = ({1'b0, read_addr} < DEPTH_EXT);
    wr_ok   = (state == S_READY) && write_en && wr_in;
    rd_word = '0;
`ifdef SRAM_1R1W_PARITY_EN
    rd_err  = 1'b0;
`endif
    if (rd_in) begin
      rd_word = mem[read_addr];
      for (int l = 0; l < LANES; l++) begin
        // Write-first: a same-cycle masked write overrides the stored lane.
        if (wr_ok && (write_addr == read_addr) && write_mask[l]) begin
          rd_word[l*LANE_W +: LANE_W] = write_data[l*LANE_W +: LANE_W];
        end
`ifdef SRAM_1R1W_PARITY_EN
        else if ((^mem[read_addr][l*LANE_W +: LANE_W]) != par_mem[read_addr][l]) begin
          rd_err = 1'b1;
        end
`endif
      end
    end
  end

  // NOTE: the array has no reset; the INIT sweep clears it instead, keeping it mappable to RAM.
  always_ff @(posedge clk) begin
    if (state == S_INIT) begin
      mem[init_cnt] <= '0;
`ifdef SRAM_1R1W_PARITY_EN
      par_mem[init_cnt] <= '0;
`endif
    end else if (wr_ok) begin
      for (int l = 0; l < LANES; l++) begin
        if (write_mask[l]) begin
          mem[write_addr][l*LANE_W +: LANE_W] <= write_data[l*LANE_W +: LANE_W];
`ifdef SRAM_1R1W_PARITY_EN
          par_mem[write_addr][l] <= ^write_data[l*LANE_W +: LANE_W];
`endif
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_INIT;
      init_cnt   <= '0;
      init_done  <= 1'b0;
      read_valid <= 1'b0;
      read_data  <= '0;
    end else begin
      unique case (state)
        S_INIT: begin
          init_cnt <= init_cnt + 1'b1;
          if (init_cnt == LAST_ADDR) begin
            state     <= S_READY;
            init_done <= 1'b1;
          end
        end
        S_READY: begin
          read_valid <= read_en;
          if (read_en) read_data <= rd_word;
        end
        default: state <= S_INIT;
      endcase
    end
  end

`ifdef SRAM_1R1W_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_err <= 1'b0;
    else        parity_err <= (state == S_READY) && read_en && rd_err;
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_1r1w_param.sv
// Self-checking bench for sram_1r1w_param: a 64-deep instance and a 48-deep instance share
// stimulus so out-of-range handling is exercised; expectations come from a word-array model.
module tb_sram_1r1w_param;
  localparam int DEPTH = 64, ODD_DEPTH = 48, WIDTH = 52, LANE_W = 13, LANES = 4, ADDR_W = 6;

  logic              clk = 1'b0, rst_n = 1'b0;
  logic              write_en = 1'b0, read_en = 1'b0;
  logic [ADDR_W-1:0] write_addr = '0, read_addr = '0;
  logic [WIDTH-1:0]  write_data = '0;
  logic [LANES-1:0]  write_mask = '0;
  logic              done_a, valid_a, perr_a, done_b, valid_b, perr_b;
  logic [WIDTH-1:0]  data_a, data_b;

  int tests = 0, fails = 0;
  logic [WIDTH-1:0] model_a [DEPTH];
  logic [WIDTH-1:0] model_b [ODD_DEPTH];
  logic [WIDTH-1:0] hold_a = '0, hold_b = '0;

  always #5 clk = ~clk;

  sram_1r1w_param #(.DEPTH(DEPTH), .WIDTH(WIDTH), .LANE_W(LANE_W)) u_a (
    .clk(clk), .rst_n(rst_n), .init_done(done_a),
    .write_en(write_en), .write_addr(write_addr), .write_data(write_data), .write_mask(write_mask),
    .read_en(read_en), .read_addr(read_addr), .read_data(data_a), .read_valid(valid_a),
    .parity_err(perr_a));

  sram_1r1w_param #(.DEPTH(ODD_DEPTH), .WIDTH(WIDTH), .LANE_W(LANE_W)) u_b (
    .clk(clk), .rst_n(rst_n), .init_done(done_b),
    .write_en(write_en), .write_addr(write_addr), .write_data(write_data), .write_mask(write_mask),
    .read_en(read_en), .read_addr(read_addr), .read_data(data_b), .read_valid(valid_b),
    .parity_err(perr_b));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] lane_merge(input logic [WIDTH-1:0] old_w,
                                                  input logic [WIDTH-1:0] new_w,
                                                  input logic [LANES-1:0] mask);
    logic [WIDTH-1:0] r;
    r = old_w;
    for (int l = 0; l < LANES; l++)
      if (mask[l]) r[l*LANE_W +: LANE_W] = new_w[l*LANE_W +: LANE_W];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_models();
    for (int i = 0; i < DEPTH; i++) model_a[i] = '0;
    for (int i = 0; i < ODD_DEPTH; i++) model_b[i] = '0;
    hold_a = '0;
    hold_b = '0;
  endtask

  // One READY-state cycle: the model applies the write, then reads (write-first), then compares.
  task automatic step(input string tag);
    logic ren;
    ren = read_en;
    if (write_en) begin
      model_a[write_addr] = lane_merge(model_a[write_addr], write_data, write_mask);
      if (int'(write_addr) < ODD_DEPTH)
        model_b[write_addr] = lane_merge(model_b[write_addr], write_data, write_mask);
    end
    if (ren) begin
      hold_a = model_a[read_addr];
      hold_b = (int'(read_addr) < ODD_DEPTH) ? model_b[read_addr] : '0;
    end
    tick();
    check({tag, "_valid_a"}, valid_a, ren);
    check({tag, "_data_a"},  data_a,  hold_a);
    check({tag, "_perr_a"},  perr_a,  1'b0);
    check({tag, "_valid_b"}, valid_b, ren);
    check({tag, "_data_b"},  data_b,  hold_b);
    check({tag, "_perr_b"},  perr_b,  1'b0);
  endtask

  initial begin
    clear_models();

    // Reset state
    #20;
    check("rst_done",  done_a,  1'b0);
    check("rst_valid", valid_a, 1'b0);
    check("rst_data",  data_a,  '0);
    check("rst_perr",  perr_a,  1'b0);

    // Init sequence with a read held on address 5
    @(negedge clk);
    rst_n = 1'b1; read_en = 1'b1; read_addr = 6'd5;
    for (int c = 1; c <= DEPTH; c++) begin
      tick();
      check("init_valid_a", valid_a, 1'b0);
      check("init_done_a", done_a, (c == DEPTH));
      if (c == ODD_DEPTH - 1 || c == ODD_DEPTH) check("init_done_b", done_b, (c == ODD_DEPTH));
    end
    step("init_read5");
    check("init_read5_zero", data_a, '0);

    // Masked write then read; read_valid exactly one cycle after read_en
    read_en = 1'b0; write_en = 1'b1; write_addr = 6'd3;
    write_data = {WIDTH{1'b1}}; write_mask = 4'b1111;
    step("mw_full");
    write_data = '0; write_mask = 4'b0101;
    step("mw_part");
    write_en = 1'b0; read_en = 1'b1; read_addr = 6'd3;
    step("mw_read");
    check("mw_const", data_a, 52'hFFF8003FFE000);
    read_en = 1'b0;
    step("mw_hold");

    // Collision bypass
    write_en = 1'b1; write_addr = 6'd7; write_data = 52'h1; write_mask = 4'b1111;
    step("col_pre");
    write_data = 52'hABCDE; write_mask = 4'b0001; read_en = 1'b1; read_addr = 6'd7;
    step("col_bypass");
    check("col_const", data_a, 52'h1CDE);
    write_en = 1'b0;
    step("col_after");

    // Back-to-back reads after mem[i] = i
    read_en = 1'b0; write_en = 1'b1; write_mask = 4'b1111;
    for (int i = 0; i < DEPTH; i++) begin
      write_addr = ADDR_W'(i); write_data = WIDTH'(i);
      step("b2b_wr");
    end
    write_en = 1'b0; read_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      read_addr = ADDR_W'(i);
      step("b2b_rd");
    end

    // Randomized traffic, half the reads aimed at the write address
    for (int n = 0; n < 400; n++) begin
      write_en   = 1'($urandom_range(0, 1));
      write_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
      write_data = WIDTH'({$urandom(), $urandom()});
      write_mask = LANES'($urandom_range(0, 15));
      read_en    = 1'($urandom_range(0, 1));
      read_addr  = $urandom_range(0, 1) ? write_addr : ADDR_W'($urandom_range(0, DEPTH - 1));
      step("rnd");
    end

    // Parity on a corrupted word
    write_en = 1'b0; read_en = 1'b1; read_addr = 6'd9;
`ifdef SRAM_1R1W_PARITY_EN
    u_a.mem[9][20] = ~u_a.mem[9][20];
    tick();
    check("par_valid", valid_a, 1'b1);
    check("par_err",   perr_a,  1'b1);
    read_en = 1'b0;
    tick();
    check("par_idle", perr_a, 1'b0);
`else
    step("par_none");
`endif

    // Reset in the middle of a read burst
    read_en = 1'b1; write_en = 1'b0;
    for (int i = 10; i < 14; i++) begin
      read_addr = ADDR_W'(i);
      step("mid_burst");
    end
    #2 rst_n = 1'b0;
    #1;
    check("mid_valid_a", valid_a, 1'b0);
    check("mid_done_a",  done_a,  1'b0);
    check("mid_data_a",  data_a,  '0);
    check("mid_valid_b", valid_b, 1'b0);
    check("mid_done_b",  done_b,  1'b0);
    tick();
    tick();
    read_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    clear_models();
    repeat (DEPTH) tick();
    check("mid_redone_a", done_a, 1'b1);
    check("mid_redone_b", done_b, 1'b1);
    read_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      read_addr = ADDR_W'(i);
      step("mid_clear");
    end
    read_en = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
